// File: rtl/vscale_hpm_counter_bank_if.sv
// Host request/response channel of the HPM counter bank.
// The master side issues single-beat register reads/writes; the slave answers each with one response beat.
interface vscale_hpm_counter_bank_if #(
  parameter int XLEN = 32
);
  logic            host_req_valid;
  logic            host_req_ready;
  logic            host_req_rw;
  logic [11:0]     host_req_addr;
  logic [XLEN-1:0] host_req_data;
  logic            host_resp_valid;
  logic            host_resp_ready;
  logic [XLEN-1:0] host_resp_data;

  modport master (
    output host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
    input  host_req_ready, host_resp_valid, host_resp_data
  );

  modport slave (
    input  host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
    output host_req_ready, host_resp_valid, host_resp_data
  );
endinterface

// File: rtl/vscale_hpm_counter_bank.sv
// Hardware performance-monitor counter bank: event counters, event selects, inhibit and sticky overflow,
// reachable from the core CSR path and from a host request/response port.
//   state   | meaning
//   IDLE    | waiting for a host request; ready unless the core is writing this cycle
//   RESP    | response held on host_resp_data until host_resp_ready
module vscale_hpm_counter_bank #(
  parameter int          XLEN       = 32,
  parameter int          CNT_WIDTH  = 64,
  parameter int          NUM_CNT    = 4,
  parameter int          NUM_EVENTS = 8,
  parameter logic [11:0] CNT_BASE   = 12'hB03,
  parameter logic [11:0] EVT_BASE   = 12'h323,
  parameter logic [11:0] INH_ADDR   = 12'h320,
  parameter logic [11:0] OVF_ADDR   = 12'h321
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                cmd,
  input  logic [11:0]               addr,
  input  logic [XLEN-1:0]           wdata,
  output logic [XLEN-1:0]           rdata,
  output logic                      hit,
  input  logic [NUM_EVENTS-1:0]     events,
  output logic                      ovf_irq,
  vscale_hpm_counter_bank_if.slave  host
);
  localparam int HI_W = CNT_WIDTH - XLEN;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  logic [CNT_WIDTH-1:0] cnt_q   [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_CNT];
  logic [XLEN-1:0]      evsel_q [NUM_CNT];
  logic [XLEN-1:0]      evsel_d [NUM_CNT];
  logic [NUM_CNT-1:0]   inh_q, inh_d;
  logic [NUM_CNT-1:0]   ovf_q, ovf_d, ovf_set;
  logic                 ovf_irq_q, ovf_irq_d;
  state_e               state_q, state_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]      resp_data_q, resp_data_d;

  logic [XLEN:0]        core_lk, host_lk;
  logic                 core_wen, host_acc, host_wen, wen;
  logic [11:0]          waddr;
  logic [XLEN-1:0]      wval, core_wval;

  // Returns {hit, read value}; unmapped addresses read as zero with hit low.
  function automatic logic [XLEN:0] lookup(input logic [11:0] a);
    logic [XLEN:0] r;
    r = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (a == CNT_BASE + 12'(i))           r = {1'b1, cnt_q[i][XLEN-1:0]};
      if (a == CNT_BASE + 12'h080 + 12'(i)) r = {1'b1, XLEN'(cnt_q[i][CNT_WIDTH-1:XLEN])};
      if (a == EVT_BASE + 12'(i))           r = {1'b1, evsel_q[i]};
    end
    if (a == INH_ADDR) r = {1'b1, XLEN'(inh_q)};
    if (a == OVF_ADDR) r = {1'b1, XLEN'(ovf_q)};
    return r;
  endfunction

  always_comb begin
    core_lk = lookup(addr);
    host_lk = lookup(host.host_req_addr);
  end

  assign {hit, rdata} = core_lk;
  assign core_wen     = cmd[2] && (cmd[1:0] != 2'b00) && hit;

  always_comb begin
    case (cmd[1:0])
      2'b10:   core_wval = rdata | wdata;
      2'b11:   core_wval = rdata & ~wdata;
      default: core_wval = wdata;
    endcase
  end

  // Core and host writes are mutually exclusive because the host is stalled while the core writes.
  assign host.host_req_ready = (state_q == ST_IDLE) && !core_wen;
  assign host_acc            = host.host_req_valid && host.host_req_ready;
  assign host_wen            = host_acc && host.host_req_rw && host_lk[XLEN];
  assign wen                 = core_wen || host_wen;
  assign waddr               = core_wen ? addr : host.host_req_addr;
  assign wval                = core_wen ? core_wval : host.host_req_data;

  always_comb begin : regs_next
    logic sel_ev, inc, wr_lo, wr_hi;
    sel_ev  = 1'b0;
    inc     = 1'b0;
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    ovf_set = '0;
    inh_d   = inh_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      sel_ev = 1'b0;
      for (int k = 0; k < NUM_EVENTS; k++) begin
        if (evsel_q[i] == XLEN'(k + 1)) sel_ev = events[k];
      end
      inc   = sel_ev && !inh_q[i];
      wr_lo = wen && (waddr == CNT_BASE + 12'(i));
      wr_hi = wen && (waddr == CNT_BASE + 12'h080 + 12'(i));
      cnt_d[i] = cnt_q[i];
      // A software write to either half suppresses that cycle's increment entirely.
      if (wr_lo) begin
        cnt_d[i][XLEN-1:0] = wval;
      end else if (wr_hi) begin
        cnt_d[i][CNT_WIDTH-1:XLEN] = wval[HI_W-1:0];
      end else if (inc) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        if (&cnt_q[i]) ovf_set[i] = 1'b1;
      end
      evsel_d[i] = (wen && (waddr == EVT_BASE + 12'(i))) ? wval : evsel_q[i];
    end
    if (wen && (waddr == INH_ADDR)) inh_d = wval[NUM_CNT-1:0];
    ovf_d     = ((wen && (waddr == OVF_ADDR)) ? wval[NUM_CNT-1:0] : ovf_q) | ovf_set;
    ovf_irq_d = |ovf_q;
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (host_acc) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = host_lk[XLEN-1:0];
        end
      end
      ST_RESP: begin
        if (host.host_resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
      inh_q        <= '0;
      ovf_q        <= '0;
      ovf_irq_q    <= 1'b0;
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]   <= cnt_d[i];
        evsel_q[i] <= evsel_d[i];
      end
      inh_q        <= inh_d;
      ovf_q        <= ovf_d;
      ovf_irq_q    <= ovf_irq_d;
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign ovf_irq              = ovf_irq_q;
  assign host.host_resp_valid = resp_valid_q;
  assign host.host_resp_data  = resp_data_q;
endmodule
